// File: rtl/int_vec_accum.sv
// Signed multiply-accumulate front end: one operand pair per cycle, summed over a
// fixed-length (or in_last-terminated) vector, emitted as a saturated 32-bit result.
module int_vec_accum #(
  parameter int IN_W    = 16,
  parameter int VEC_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int GRD_W   = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] term_cnt
);

  localparam int P_W = 2 * IN_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  logic                    stall;
  logic                    xfer;
  logic                    acc_en;
  logic                    close;
  logic                    pos_ovf;
  logic                    neg_ovf;
  logic signed [P_W-1:0]   prod;
  logic                    p_last;
  logic                    p_valid;
  logic signed [GRD_W-1:0] acc;
  logic signed [GRD_W-1:0] sum;

  // The whole pipeline freezes only while a finished result is waiting downstream.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign xfer     = in_valid & in_ready;
  assign acc_en   = p_valid & ~stall;

  assign sum   = acc + {{(GRD_W - P_W){prod[P_W-1]}}, prod};
  assign close = p_last | (term_cnt == LAST_CNT);

  // The sum fits in 32 bits only when bits GRD_W-1 down to 31 are all equal.
  assign pos_ovf = ~sum[GRD_W-1] & (|sum[GRD_W-2:31]);
  assign neg_ovf =  sum[GRD_W-1] & ~(&sum[GRD_W-2:31]);

  // NOTE: all state is updated with non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the always_ff blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod    <= '0;
      p_last  <= 1'b0;
      p_valid <= 1'b0;
    end else if (xfer) begin
      prod    <= $signed(in_a) * $signed(in_b);
      p_last  <= in_last;
      p_valid <= 1'b1;
    end else if (!stall) begin
      p_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      term_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (acc_en) begin
        if (close) begin
          acc      <= '0;
          term_cnt <= '0;
        end else begin
          acc      <= sum;
          term_cnt <= term_cnt + 1'b1;
        end
      end

      // A close in the same cycle as a consume replaces the result back-to-back.
      if (acc_en && close) begin
        out_valid <= 1'b1;
        out_sat   <= pos_ovf | neg_ovf;
        if (pos_ovf)      out_data <= 32'h7FFF_FFFF;
        else if (neg_ovf) out_data <= 32'h8000_0000;
        else              out_data <= sum[31:0];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
